// File: rtl/seg_num_display_if.sv
// Bus bundle for the 7-segment number display driver: configuration/value inputs,
// ready/done handshake and the raw active-low segment bytes.
interface seg_num_display_if #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14
);
    logic                  en;
    logic                  hex;
    logic                  lzb;
    logic                  load;
    logic [WIDTH-1:0]      value;
    logic                  ready;
    logic                  done;
    logic [DIGITS*8-1:0]   seg;

    modport master (
        output en, hex, lzb, load, value,
        input  ready, done, seg
    );

    modport slave (
        input  en, hex, lzb, load, value,
        output ready, done, seg
    );
endinterface

// File: rtl/seg_num_display.sv
// Multi-digit static 7-segment driver: latches a binary value on load, converts it to hex
// or decimal (sequential double-dabble) digits and holds the encoded segment bytes.
module seg_num_display #(
    parameter int DIGITS = 4,
    parameter int WIDTH  = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    seg_num_display_if.slave  bus
);

    // Decimal digits needed to hold the largest WIDTH-bit value, so overflow never wraps.
    function automatic int calc_bcd_digits(input int w);
        longint m;
        int     n;
        m = (64'd1 << w) - 64'd1;
        n = 1;
        while (m >= 64'd10) begin
            m = m / 64'd10;
            n = n + 1;
        end
        return n;
    endfunction

    localparam int BCDN = calc_bcd_digits(WIDTH);
    localparam int NB   = (BCDN > DIGITS) ? BCDN : DIGITS;
    localparam int CW   = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    function automatic logic [7:0] encode(input logic [3:0] nib);
        case (nib)
            4'h0:    encode = 8'hC0;
            4'h1:    encode = 8'hF9;
            4'h2:    encode = 8'hA4;
            4'h3:    encode = 8'hB0;
            4'h4:    encode = 8'h99;
            4'h5:    encode = 8'h92;
            4'h6:    encode = 8'h82;
            4'h7:    encode = 8'hF8;
            4'h8:    encode = 8'h80;
            4'h9:    encode = 8'h90;
            4'hA:    encode = 8'h88;
            4'hB:    encode = 8'h83;
            4'hC:    encode = 8'hC6;
            4'hD:    encode = 8'hA1;
            4'hE:    encode = 8'h86;
            default: encode = 8'h8E;
        endcase
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        SHOW
    } state_t;

    state_t                state;
    logic                  ready_r;
    logic                  done_r;
    logic [DIGITS*8-1:0]   disp;
    logic [WIDTH-1:0]      sh;
    logic [4*NB-1:0]       bcd;
    logic [4*NB-1:0]       bcd_adj;
    logic [CW-1:0]         cnt;
    logic                  hexm;
    logic                  lzbm;
    logic [4*NB-1:0]       digs;
    logic                  ovf;
    logic                  seen;
    logic [3:0]            nib;
    logic [DIGITS*8-1:0]   next_disp;

    always_comb begin
        bcd_adj = bcd;
        for (int j = 0; j < NB; j++) begin
            if (bcd[4*j +: 4] >= 4'd5) begin
                bcd_adj[4*j +: 4] = bcd[4*j +: 4] + 4'd3;
            end
        end
    end

    // Digit source is either the raw value nibbles or the finished BCD scratch; anything
    // non-zero above the displayed digits means the number does not fit.
    always_comb begin
        digs = '0;
        if (hexm) begin
            digs[WIDTH-1:0] = sh;
        end else begin
            digs = bcd;
        end
        ovf       = |(digs >> (4 * DIGITS));
        seen      = 1'b0;
        nib       = 4'h0;
        next_disp = '1;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = digs[4*i +: 4];
            if (ovf) begin
                next_disp[8*i +: 8] = 8'hBF;
            end else if (lzbm && !seen && nib == 4'h0 && i != 0) begin
                next_disp[8*i +: 8] = 8'hFF;
            end else begin
                next_disp[8*i +: 8] = encode(nib);
            end
            if (nib != 4'h0) begin
                seen = 1'b1;
            end
        end
    end

    // ready stays low for one settle cycle after SHOW so it rises the cycle after done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
            disp    <= '1;
            sh      <= '0;
            bcd     <= '0;
            cnt     <= '0;
            hexm    <= 1'b0;
            lzbm    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (!ready_r) begin
                        ready_r <= 1'b1;
                    end else if (bus.load) begin
                        sh      <= bus.value;
                        bcd     <= '0;
                        cnt     <= '0;
                        hexm    <= bus.hex;
                        lzbm    <= bus.lzb;
                        ready_r <= 1'b0;
                        state   <= bus.hex ? SHOW : CONV;
                    end
                end
                CONV: begin
                    bcd <= {bcd_adj[4*NB-2:0], sh[WIDTH-1]};
                    sh  <= sh << 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        state <= SHOW;
                    end
                end
                SHOW: begin
                    disp   <= next_disp;
                    done_r <= 1'b1;
                    state  <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready = ready_r;
    assign bus.done  = done_r;
    assign bus.seg   = bus.en ? disp : '1;

endmodule

// File: tb/tb_seg_num_display.sv
// Directed bench for seg_num_display: a 4-digit and a 3-digit instance, each scenario
// in its own task with inline expected-value comparisons.
module tb_seg_num_display;

    logic clk;
    logic rst_n;
    int   checks;
    int   fails;

    seg_num_display_if #(.DIGITS(4), .WIDTH(14)) b4 ();
    seg_num_display_if #(.DIGITS(3), .WIDTH(14)) b3 ();

    seg_num_display #(.DIGITS(4), .WIDTH(14)) dut4 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b4)
    );

    seg_num_display #(.DIGITS(3), .WIDTH(14)) dut3 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues a load on the 4-digit instance; dc = cycle of done (-1 if none), rh = cycles ready was high.
    task automatic run4(input logic [13:0] v, input logic h, input logic z,
                        output int dc, output int rh);
        b4.value = v;
        b4.hex   = h;
        b4.lzb   = z;
        b4.load  = 1'b1;
        step();
        b4.load  = 1'b0;
        dc = -1;
        rh = 0;
        for (int k = 1; k <= 40; k++) begin
            if (b4.ready) rh++;
            if (b4.done) begin
                dc = k;
                break;
            end
            step();
        end
    endtask

    task automatic run3(input logic [13:0] v, output int dc);
        b3.value = v;
        b3.hex   = 1'b1;
        b3.lzb   = 1'b0;
        b3.load  = 1'b1;
        step();
        b3.load  = 1'b0;
        dc = -1;
        for (int k = 1; k <= 20; k++) begin
            if (b3.done) begin
                dc = k;
                break;
            end
            step();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        checks++;
        if (b4.seg !== 32'hFFFFFFFF) begin
            fails++;
            $display("[TB] FAIL reset_seg: got %h expected %h", b4.seg, 32'hFFFFFFFF);
        end
        checks++;
        if (b4.ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL reset_ready: got %b expected 1", b4.ready);
        end
        checks++;
        if (b4.done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_done: got %b expected 0", b4.done);
        end
        checks++;
        if (b3.seg !== 24'hFFFFFF) begin
            fails++;
            $display("[TB] FAIL reset_seg3: got %h expected %h", b3.seg, 24'hFFFFFF);
        end
    endtask

    task automatic test_decimal();
        int dc;
        int rh;
        run4(14'd1234, 1'b0, 1'b0, dc, rh);
        checks++;
        if (dc !== 16) begin
            fails++;
            $display("[TB] FAIL dec_latency: got %0d expected 16", dc);
        end
        checks++;
        if (rh !== 0) begin
            fails++;
            $display("[TB] FAIL dec_ready_low: ready high %0d cycles expected 0", rh);
        end
        checks++;
        if (b4.seg !== 32'hF9A4B099) begin
            fails++;
            $display("[TB] FAIL dec_1234: got %h expected %h", b4.seg, 32'hF9A4B099);
        end
        step();
        checks++;
        if (b4.done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL dec_done_pulse: got %b expected 0", b4.done);
        end
        checks++;
        if (b4.ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL dec_ready_back: got %b expected 1", b4.ready);
        end
    endtask

    task automatic test_hex();
        int dc;
        int rh;
        run4(14'h2BEF, 1'b1, 1'b0, dc, rh);
        checks++;
        if (dc !== 2) begin
            fails++;
            $display("[TB] FAIL hex_latency: got %0d expected 2", dc);
        end
        checks++;
        if (b4.seg !== 32'hA483868E) begin
            fails++;
            $display("[TB] FAIL hex_2BEF: got %h expected %h", b4.seg, 32'hA483868E);
        end
        step();
        run4(14'h00A0, 1'b1, 1'b1, dc, rh);
        checks++;
        if (b4.seg !== 32'hFFFF88C0) begin
            fails++;
            $display("[TB] FAIL hex_lzb_00A0: got %h expected %h", b4.seg, 32'hFFFF88C0);
        end
        step();
        run3(14'h3FFF, dc);
        checks++;
        if (dc !== 2) begin
            fails++;
            $display("[TB] FAIL hex3_latency: got %0d expected 2", dc);
        end
        checks++;
        if (b3.seg !== 24'hBFBFBF) begin
            fails++;
            $display("[TB] FAIL hex3_overflow: got %h expected %h", b3.seg, 24'hBFBFBF);
        end
        step();
        run3(14'h0ABC, dc);
        checks++;
        if (b3.seg !== 24'h8883C6) begin
            fails++;
            $display("[TB] FAIL hex3_0ABC: got %h expected %h", b3.seg, 24'h8883C6);
        end
        step();
    endtask

    task automatic test_overflow_lzb();
        int dc;
        int rh;
        run4(14'd10000, 1'b0, 1'b0, dc, rh);
        checks++;
        if (b4.seg !== 32'hBFBFBFBF) begin
            fails++;
            $display("[TB] FAIL dec_10000_ovf: got %h expected %h", b4.seg, 32'hBFBFBFBF);
        end
        step();
        run4(14'd16383, 1'b0, 1'b1, dc, rh);
        checks++;
        if (b4.seg !== 32'hBFBFBFBF) begin
            fails++;
            $display("[TB] FAIL dec_16383_ovf: got %h expected %h", b4.seg, 32'hBFBFBFBF);
        end
        step();
        run4(14'd9999, 1'b0, 1'b0, dc, rh);
        checks++;
        if (b4.seg !== 32'h90909090) begin
            fails++;
            $display("[TB] FAIL dec_9999: got %h expected %h", b4.seg, 32'h90909090);
        end
        step();
        run4(14'd0, 1'b0, 1'b0, dc, rh);
        checks++;
        if (b4.seg !== 32'hC0C0C0C0) begin
            fails++;
            $display("[TB] FAIL dec_0_nolzb: got %h expected %h", b4.seg, 32'hC0C0C0C0);
        end
        step();
        run4(14'd7, 1'b0, 1'b1, dc, rh);
        checks++;
        if (b4.seg !== 32'hFFFFFFF8) begin
            fails++;
            $display("[TB] FAIL dec_lzb_7: got %h expected %h", b4.seg, 32'hFFFFFFF8);
        end
        step();
        run4(14'd0, 1'b0, 1'b1, dc, rh);
        checks++;
        if (b4.seg !== 32'hFFFFFFC0) begin
            fails++;
            $display("[TB] FAIL dec_lzb_0: got %h expected %h", b4.seg, 32'hFFFFFFC0);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int dones;
        int dc;
        dones = 0;
        dc    = -1;
        b4.value = 14'd1234;
        b4.hex   = 1'b0;
        b4.lzb   = 1'b0;
        b4.load  = 1'b1;
        step();
        b4.load  = 1'b0;
        for (int k = 1; k <= 30; k++) begin
            if (b4.done) begin
                dones++;
                if (dc < 0) dc = k;
            end
            if (k == 12 || k == 16) begin
                checks++;
                if (b4.seg !== 32'hFFFFFFFF) begin
                    fails++;
                    $display("[TB] FAIL en_off_seg_c%0d: got %h expected %h", k, b4.seg, 32'hFFFFFFFF);
                end
            end
            if (k == 5) begin
                b4.value = 14'd9;
                b4.load  = 1'b1;
            end else if (k == 6) begin
                b4.load  = 1'b0;
            end
            if (k == 8) b4.en = 1'b0;
            if (k == 20) b4.en = 1'b1;
            step();
        end
        checks++;
        if (dones !== 1) begin
            fails++;
            $display("[TB] FAIL b2b_done_count: got %0d expected 1", dones);
        end
        checks++;
        if (dc !== 16) begin
            fails++;
            $display("[TB] FAIL b2b_latency: got %0d expected 16", dc);
        end
        checks++;
        if (b4.seg !== 32'hF9A4B099) begin
            fails++;
            $display("[TB] FAIL b2b_shows_1234: got %h expected %h", b4.seg, 32'hF9A4B099);
        end
    endtask

    task automatic test_mid_reset();
        int dones;
        dones = 0;
        b4.value = 14'd1234;
        b4.hex   = 1'b0;
        b4.lzb   = 1'b0;
        b4.load  = 1'b1;
        step();
        b4.load  = 1'b0;
        for (int k = 1; k < 8; k++) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (b4.ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL midrst_ready: got %b expected 1", b4.ready);
        end
        checks++;
        if (b4.seg !== 32'hFFFFFFFF) begin
            fails++;
            $display("[TB] FAIL midrst_seg: got %h expected %h", b4.seg, 32'hFFFFFFFF);
        end
        for (int k = 0; k < 20; k++) begin
            if (b4.done) dones++;
            step();
        end
        checks++;
        if (dones !== 0) begin
            fails++;
            $display("[TB] FAIL midrst_late_done: got %0d pulses expected 0", dones);
        end
    endtask

    initial begin
        checks   = 0;
        fails    = 0;
        rst_n    = 1'b0;
        b4.en    = 1'b1;
        b4.hex   = 1'b0;
        b4.lzb   = 1'b0;
        b4.load  = 1'b0;
        b4.value = '0;
        b3.en    = 1'b1;
        b3.hex   = 1'b0;
        b3.lzb   = 1'b0;
        b3.load  = 1'b0;
        b3.value = '0;
        #1;
        test_reset();
        test_decimal();
        test_hex();
        test_overflow_lzb();
        test_back_to_back();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
